// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter and its clients.
//   - arb_state_e : access sequencer states (IDLE must stay encoded as 0)
//   - ADDR_W_DEF / DATA_W_DEF : memory geometry shared with the data memory
//     and the control unit
//   - WE_READ / WE_WRITE : encoding of the per-requester we bit
//   - gid_width() : width of a requester index, never narrower than 1 bit
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    localparam logic WE_READ  = 1'b0;
    localparam logic WE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // A single requester still needs a 1-bit index signal.
    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the unmasked requests starting
// at ptr_i+1 and wrapping modulo NREQ; the first hit wins.
//   req_i  : request vector
//   mask_i : requests to ignore (the requester just acknowledged)
//   ptr_i  : index of the most recently served requester
//   win_o  : winning index (0 when any_o is low)
//   any_o  : at least one unmasked request is present
// -----------------------------------------------------------------------------
module rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int GW   = gid_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] mask_i,
    input  logic [GW-1:0]   ptr_i,
    output logic [GW-1:0]   win_o,
    output logic            any_o
);

    logic [NREQ-1:0] elig;

    assign elig = req_i & ~mask_i;

    // Distance k from the pointer sets priority; the nested loop keeps every
    // bit select constant after unrolling.
    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!any_o && elig[j] && (j == ((int'(ptr_i) + k) % NREQ))) begin
                    any_o = 1'b1;
                    win_o = GW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between NREQ requesters (index 0 is the
// control unit). Each granted access runs ISSUE -> WAIT -> DONE: one strobe
// cycle, one cycle for the memory's registered output, one ack cycle.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   req, we      : per-requester request level and write select
//   addr, wdata  : packed per-requester line address / write data
//   ack          : one-cycle completion pulse for the served requester
//   rdata        : read data, valid in the ack cycle of a read, else held
//   busy         : sequencer is not idle
//   grant_id     : index of the requester being served
//   mem_read     : memory memRead
//   mem_write    : memory memWrite
//   line_number  : memory lineNumber
//   mem_in       : memory memIn
//   mem_out      : memory memOut
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter  int NREQ   = 2,
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int GW     = gid_width(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic [GW-1:0]            grant_id,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        line_number,
    output logic [DATA_W-1:0]        mem_in,
    input  logic [DATA_W-1:0]        mem_out
);

    arb_state_e         state_q;
    logic [GW-1:0]      ptr_q;
    logic [GW-1:0]      gid_q;
    logic               we_q;
    logic [NREQ-1:0]    ack_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  line_q;      // doubles as the latched address
    logic [DATA_W-1:0]  mem_in_q;    // doubles as the latched write data

    // Arbitration inputs: IDLE searches from the stored pointer with no mask;
    // DONE searches from the requester being acked and masks it, so a
    // requester still holding req on its ack edge is not granted twice.
    logic               in_done;
    logic [NREQ-1:0]    pick_mask;
    logic [GW-1:0]      pick_ptr;
    logic [GW-1:0]      win;
    logic               win_any;
    logic [NREQ-1:0]    gid_onehot;

    // Fields of the winning requester
    logic               win_we_d;
    logic [ADDR_W-1:0]  win_addr_d;
    logic [DATA_W-1:0]  win_wdata_d;

    assign in_done = (state_q == ST_DONE);

    always_comb begin
        gid_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GW'(i) == gid_q) begin
                gid_onehot[i] = 1'b1;
            end
        end
    end

    assign pick_mask = in_done ? gid_onehot : '0;
    assign pick_ptr  = in_done ? gid_q : ptr_q;

    rr_pick #(
        .NREQ   (NREQ)
    ) u_rr_pick (
        .req_i  (req),
        .mask_i (pick_mask),
        .ptr_i  (pick_ptr),
        .win_o  (win),
        .any_o  (win_any)
    );

    always_comb begin
        win_we_d    = WE_READ;
        win_addr_d  = '0;
        win_wdata_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GW'(i) == win) begin
                win_we_d    = we[i];
                win_addr_d  = addr[i*ADDR_W +: ADDR_W];
                win_wdata_d = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Sequencer. Strobes and ack are single-cycle pulses: cleared by default
    // and set only on the edge that enters ISSUE (strobes) or DONE (ack).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= GW'(NREQ - 1);
            gid_q       <= '0;
            we_q        <= WE_READ;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            line_q      <= '0;
            mem_in_q    <= '0;
        end else begin
            ack_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (in_done) begin
                        ptr_q <= gid_q;
                    end
                    if (win_any) begin
                        state_q     <= ST_ISSUE;
                        gid_q       <= win;
                        we_q        <= win_we_d;
                        line_q      <= win_addr_d;
                        mem_in_q    <= win_wdata_d;
                        mem_read_q  <= (win_we_d == WE_READ);
                        mem_write_q <= (win_we_d == WE_WRITE);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // memOut is registered in the memory, so it is valid here.
                    state_q <= ST_DONE;
                    ack_q   <= gid_onehot;
                    if (we_q == WE_READ) begin
                        rdata_q <= mem_out;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = gid_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign line_number = line_q;
    assign mem_in      = mem_in_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 3;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      we  = '0;
  logic [NREQ*AW-1:0]   addr = '0;
  logic [NREQ*DW-1:0]   wdata = '0;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        rdata;
  logic                 busy;
  logic                 grant_id;
  logic                 mem_read;
  logic                 mem_write;
  logic [AW-1:0]        line_number;
  logic [DW-1:0]        mem_in;
  logic [DW-1:0]        mem_out = '0;

  dmem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .mem_read(mem_read), .mem_write(mem_write), .line_number(line_number),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, write on the strobe edge.
  logic [DW-1:0] pmem [8] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_read)  mem_out <= pmem[line_number];
    if (mem_write) pmem[line_number] <= mem_in;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: transaction view. m_ph counts cycles since grant
  // (-1 idle, 0 strobe cycle, 1 memory cycle, 2 ack cycle). Decisions are made
  // on edges where the model is idle or finishing an ack.
  // ---------------------------------------------------------------------------
  int            m_ph  = -1;
  int            m_own = 0;
  int            m_ptr = NREQ - 1;
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] mmem [8] = '{default: 8'h00};
  logic [NREQ-1:0] m_elig;
  int            m_w;

  function automatic int rr(input logic [NREQ-1:0] elig, input int after);
    for (int k = 1; k <= NREQ; k++)
      if (elig[(after + k) % NREQ]) return (after + k) % NREQ;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ph = -1; m_own = 0; m_ptr = NREQ - 1; m_rdata = '0;
      end else if (m_ph == 0) begin
        if (m_we) mmem[m_addr] = m_wd;
        m_ph = 1;
      end else if (m_ph == 1) begin
        if (!m_we) m_rdata = mmem[m_addr];
        m_ph = 2;
      end else begin
        m_elig = req;
        if (m_ph == 2) begin
          m_elig[m_own] = 1'b0;
          m_ptr = m_own;
        end
        m_w = rr(m_elig, m_ptr);
        if (m_w < 0) m_ph = -1;
        else begin
          m_own  = m_w;
          m_we   = we[m_w];
          m_addr = addr[m_w*AW +: AW];
          m_wd   = wdata[m_w*DW +: DW];
          m_ph   = 0;
        end
      end
    end
  end

  // Per-cycle compare plus strobe/ack counters.
  int n_wr = 0, n_rd = 0, n_ack0 = 0, n_ack1 = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy", busy, m_ph != -1);
        chk("ack", ack, (m_ph == 2) ? (32'd1 << m_own) : 32'd0);
        chk("mem_read", mem_read, (m_ph == 0) && !m_we);
        chk("mem_write", mem_write, (m_ph == 0) && m_we);
        chk("rdata", rdata, m_rdata);
        if (m_ph >= 0) chk("grant_id", grant_id, m_own);
        if (m_ph == 0 || m_ph == 1) chk("line_number", line_number, m_addr);
        if (m_ph == 0 && m_we) chk("mem_in", mem_in, m_wd);
        if (mem_write) n_wr++;
        if (mem_read) n_rd++;
        if (ack[0]) n_ack0++;
        if (ack[1]) n_ack1++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic w, input int a, input int d);
    logic [31:0] av, dv;
    av = a; dv = d;
    we[i] = w;
    addr[i*AW +: AW] = av[AW-1:0];
    wdata[i*DW +: DW] = dv[DW-1:0];
    req[i] = 1'b1;
  endtask

  task automatic wait_ack(input int i, output int c);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (ack[i] || n > 30) break;
      n++;
    end
    chk($sformatf("ack%0d_seen", i), ack[i], 1);
    c = cyc;
  endtask

  task automatic wait_any(output int who, output int c);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (ack != 0 || n > 30) break;
      n++;
    end
    chk("ack_any_seen", ack != 0, 1);
    who = ack[1] ? 1 : 0;
    c = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n > 20) break;
      n++;
    end
    chk("back_to_idle", busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, c, c1, who, a1;
    int seq_who[4];
    int seq_c[4];

    // Reset values
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_line", line_number, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_grant", grant_id, 0);
    tick();
    rst = 1'b0;

    // Single write then read of line 3
    tick();
    c0 = cyc;
    set_req(0, 1'b1, 3, 8'hA5);
    wait_ack(0, c);
    chk("wr_latency", c - c0, 3);
    tick();
    req[0] = 1'b0;
    chk("wr_mem_line3", pmem[3], 8'hA5);
    c0 = cyc;
    set_req(0, 1'b0, 3, 0);
    wait_ack(0, c);
    chk("rd_latency", c - c0, 3);
    chk("rd_data_A5", rdata, 8'hA5);
    tick();
    req[0] = 1'b0;
    chk("wr_strobe_count", n_wr, 1);
    chk("rd_strobe_count", n_rd, 1);

    // Reset in the middle of a write's ISSUE cycle
    set_req(0, 1'b1, 6, 8'h77);
    tick();
    @(negedge clk);
    chk("issue_wr_high", mem_write, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_wr_drop", mem_write, 0);
    chk("rst_no_ack", ack, 0);
    req = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rdata", rdata, 0);
    chk("post_rst_line", line_number, 0);
    chk("post_rst_mem_in", mem_in, 0);
    chk("post_rst_grant", grant_id, 0);
    repeat (3) @(negedge clk);
    chk("post_rst_no_ack", n_ack0, 2);
    chk("aborted_write", pmem[6], 8'h00);

    // Simultaneous requests from reset: 0 reads line 1, 1 writes 0x3C there
    tick();
    rst = 1'b1;
    set_req(0, 1'b0, 1, 0);
    set_req(1, 1'b1, 1, 8'h3C);
    tick();
    rst = 1'b0;
    c0 = cyc;
    wait_ack(0, c);
    chk("sim_first_latency", c - c0, 3);
    chk("sim_old_value", rdata, 8'h00);
    tick();
    req[0] = 1'b0;
    wait_ack(1, c1);
    chk("sim_ack_gap", c1 - c, 3);
    tick();
    req[1] = 1'b0;
    set_req(0, 1'b0, 1, 0);
    wait_ack(0, c);
    chk("sim_new_value", rdata, 8'h3C);
    tick();
    req[0] = 1'b0;

    // Fairness: both hold req continuously from a fresh reset
    rst = 1'b1;
    set_req(0, 1'b0, 3, 0);
    set_req(1, 1'b0, 1, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_any(who, c);
      seq_who[k] = who;
      seq_c[k] = c;
    end
    tick();
    req = '0;
    for (int k = 0; k < 4; k++) chk($sformatf("fair_order%0d", k), seq_who[k], k % 2);
    for (int k = 1; k < 4; k++) chk($sformatf("fair_gap%0d", k), seq_c[k] - seq_c[k-1], 3);
    wait_idle();

    // Mid-transaction change: requester 1 writes 0x5A to line 5, then drops
    // req and moves addr to 2 right after the grant.
    tick();
    a1 = n_ack1;
    set_req(1, 1'b1, 5, 8'h5A);
    tick();
    req[1] = 1'b0;
    addr[1*AW +: AW] = 3'd2;
    wdata[1*DW +: DW] = 8'hFF;
    wait_ack(1, c);
    repeat (3) tick();
    chk("mid_ack_once", n_ack1 - a1, 1);
    chk("mid_line5", pmem[5], 8'h5A);
    chk("mid_line2", pmem[2], 8'h00);

    // Re-request suppression: req0 held one cycle past its ack
    set_req(0, 1'b0, 5, 0);
    wait_ack(0, c);
    chk("rereq_data", rdata, 8'h5A);
    tick();
    @(negedge clk);
    chk("rereq_no_double_grant", busy, 0);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("rereq_from_idle", busy, 1);
    chk("rereq_grant", grant_id, 0);
    wait_ack(0, c1);
    chk("rereq_ack_gap", c1 - c, 4);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
